// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt aggregator: register offsets, FSM states, timer source index.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional round-robin arbitration is enabled by IRQ_AGGREGATOR_ROUNDROBIN_EN.
package irq_pkg;

  // Byte offsets of the MMIO registers; a[3:2] selects among them
  localparam logic [3:0] IRQ_PENDING = 4'h0;
  localparam logic [3:0] IRQ_ENABLE  = 4'h4;
  localparam logic [3:0] IRQ_CLAIMED = 4'h8;

  // Arbitration FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t WAIT = 2'd2;

  // Source 0 is always the machine timer
  localparam int TIMER_SRC = 0;

  // Register-select field of a byte offset
  function automatic logic [1:0] reg_sel(input logic [3:0] off);
    return off[3:2];
  endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Priority encoder: first set request at or after 'start', wrapping around to index 0.
// Latency: purely combinational.
// Backpressure: none; start must be below N.
module irq_prio_sel #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   start,
  output logic         vld,
  output logic [3:0]   idx
);

  // Wrapped region (below start) first, then the region at/after start overrides it;
  // descending loops leave the lowest index of each region as the winner.
  always_comb begin
    vld = 1'b0;
    idx = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i < int'(start))) begin
        vld = 1'b1;
        idx = 4'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(start))) begin
        vld = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// Latches interrupt pulses as pending and presents one arbitrated request on eip until eip_reply.
// Latency: irq pulse -> pending next cycle -> eip the cycle after; HOLDOFF idle cycles follow each reply.
// Backpressure: eip holds stable until eip_reply; IRQ_AGGREGATOR_ROUNDROBIN_EN selects round-robin for non-timer sources.
module irq_aggregator
  import irq_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic [3:0]       a,
  input  logic [31:0]      d,
  input  logic             we,
  output logic [31:0]      spo,
  output logic             eip,
  output logic             eip_istimer,
  input  logic             eip_reply
);

  logic [N_SRC-1:0] pending, enable, req, w1c, rclr;
  logic             claimed_vld;
  logic [3:0]       claimed_id;
  state_t           state, state_nxt;
  logic [3:0]       sel, sel_nxt, cnt, cnt_nxt;
  logic             eip_nxt, ist_nxt;
  logic             arb_vld;
  logic [3:0]       arb_idx;
  logic             reply_acc, wr_pend, wr_en;
  logic             unused_bits;

  assign req         = pending & enable;
  assign reply_acc   = (state == REQ) && eip_reply;
  assign wr_pend     = we && (a[3:2] == reg_sel(IRQ_PENDING));
  assign wr_en       = we && (a[3:2] == reg_sel(IRQ_ENABLE));
  assign w1c         = wr_pend ? d[N_SRC-1:0] : '0;
  assign unused_bits = ^{d[31:N_SRC], a[1:0]};

`ifdef IRQ_AGGREGATOR_ROUNDROBIN_EN
  logic [3:0]       last_granted, rr_start, rr_idx;
  logic [N_SRC-1:0] rr_req;
  logic             rr_vld;

  // Non-timer search starts one past the last grant, wrapping back to source 1
  always_comb begin
    rr_req            = req;
    rr_req[TIMER_SRC] = 1'b0;
    rr_start          = (last_granted >= 4'(N_SRC - 1)) ? 4'd1 : last_granted + 4'd1;
  end

  irq_prio_sel #(.N(N_SRC)) u_sel (
    .req   (rr_req),
    .start (rr_start),
    .vld   (rr_vld),
    .idx   (rr_idx)
  );

  // Timer keeps absolute priority over the rotating sources
  always_comb begin
    arb_vld = req[TIMER_SRC] | rr_vld;
    arb_idx = req[TIMER_SRC] ? 4'(TIMER_SRC) : rr_idx;
  end

  // Remember the source that was last acknowledged
  always_ff @(posedge clk) begin
    if (rst)            last_granted <= 4'd0;
    else if (reply_acc) last_granted <= sel;
  end
`else
  irq_prio_sel #(.N(N_SRC)) u_sel (
    .req   (req),
    .start (4'd0),
    .vld   (arb_vld),
    .idx   (arb_idx)
  );
`endif

  // One-hot clear of the granted source on acknowledge
  always_comb begin
    rclr = '0;
    for (int i = 0; i < N_SRC; i++) rclr[i] = reply_acc && (sel == 4'(i));
  end

  // Pending/enable/claimed registers; a new pulse beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= '0;
      enable      <= '0;
      claimed_vld <= 1'b0;
      claimed_id  <= 4'd0;
    end else begin
      pending <= (pending & ~(w1c | rclr)) | irq;
      if (wr_en) enable <= d[N_SRC-1:0];
      if (reply_acc) begin
        claimed_vld <= 1'b1;
        claimed_id  <= sel;
      end
    end
  end

  // FSM state register with registered request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= 4'd0;
      cnt         <= 4'd0;
      eip         <= 1'b0;
      eip_istimer <= 1'b0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      cnt         <= cnt_nxt;
      eip         <= eip_nxt;
      eip_istimer <= ist_nxt;
    end
  end

  // Next-state: grant in IDLE, wait for reply in REQ (sel frozen), count down HOLDOFF in WAIT
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (arb_vld) begin
        state_nxt = REQ;
        sel_nxt   = arb_idx;
      end
      REQ: if (eip_reply) begin
        state_nxt = WAIT;
        cnt_nxt   = 4'(HOLDOFF);
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs follow the upcoming state; withdrawal of pending/enable cannot drop a live request
  always_comb begin
    eip_nxt = (state_nxt == REQ);
    ist_nxt = (state_nxt == REQ) && (sel_nxt == 4'(TIMER_SRC));
  end

  // Combinational MMIO read mux
  always_comb begin
    spo = 32'd0;
    case (a[3:2])
      reg_sel(IRQ_PENDING): spo = {{(32-N_SRC){1'b0}}, pending};
      reg_sel(IRQ_ENABLE):  spo = {{(32-N_SRC){1'b0}}, enable};
      reg_sel(IRQ_CLAIMED): spo = {27'd0, claimed_vld, claimed_id};
      default:              spo = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_irq_aggregator.sv
// Self-checking bench for irq_aggregator: register-level vector table plus scoreboarded grant sequences.
// Latency: one bench step per clock; outputs sampled 2 time units after the rising edge.
// Backpressure: eip waits are bounded; an expired wait counts as a failed check.
module tb_irq_aggregator;
  import irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  irq = '0;
  logic [3:0]  a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0;
  logic [31:0] spo;
  logic        eip, eip_istimer;
  logic        eip_reply = 1'b0;

  int checks = 0;
  int errors = 0;

  irq_aggregator #(.N_SRC(4), .HOLDOFF(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .a           (a),
    .d           (d),
    .we          (we),
    .spo         (spo),
    .eip         (eip),
    .eip_istimer (eip_istimer),
    .eip_reply   (eip_reply)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ir;
    logic        rp;
    logic [3:0]  ra;
    logic [31:0] exp_spo;
    logic        exp_eip;
    logic        exp_ist;
  } vec_t;

  typedef struct {
    logic        ist;
    logic [31:0] claimed;
  } exp_t;

  vec_t tbl[19];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then park the read address and sample after the edge
  task automatic step(input logic w, input logic [3:0] wa, input logic [31:0] wd,
                      input logic [3:0] ir, input logic rp, input logic [3:0] ra);
    @(negedge clk);
    we = w; a = wa; d = wd; irq = ir; eip_reply = rp;
    @(posedge clk);
    #1;
    we = 1'b0; irq = '0; eip_reply = 1'b0; a = ra;
    #1;
  endtask

  task automatic idle(input logic [3:0] ra);
    step(1'b0, 4'h0, 32'd0, 4'h0, 1'b0, ra);
  endtask

  task automatic wait_eip();
    int n = 0;
    while (!eip && n < 40) begin
      idle(IRQ_CLAIMED);
      n++;
    end
    chk("eip_wait_timeout", {31'd0, (n >= 40)}, 32'd0);
  endtask

  // Pop the next expected grant when the DUT raises eip, hold, then reply
  task automatic service(input logic [3:0] extra, input int hold);
    exp_t e;
    e.ist = 1'b0;
    e.claimed = 32'hDEAD;
    wait_eip();
    chk("sb_nonempty", {31'd0, (sb.size() == 0)}, 32'd0);
    if (sb.size() != 0) e = sb.pop_front();
    chk("grant_istimer", {31'd0, eip_istimer}, {31'd0, e.ist});
    for (int h = 0; h < hold; h++) begin
      idle(IRQ_CLAIMED);
      chk("hold_eip", {31'd0, eip}, 32'd1);
      chk("hold_istimer", {31'd0, eip_istimer}, {31'd0, e.ist});
    end
    step(1'b0, 4'h0, 32'd0, extra, 1'b1, IRQ_CLAIMED);
    chk("claimed", spo, e.claimed);
    chk("eip_drop", {31'd0, eip}, 32'd0);
  endtask

  function automatic vec_t mk(input logic wr, input logic [3:0] wa, input logic [31:0] wd,
                              input logic [3:0] ir, input logic rp, input logic [3:0] ra,
                              input logic [31:0] es, input logic ee, input logic ei);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.ir = ir; v.rp = rp; v.ra = ra;
    v.exp_spo = es; v.exp_eip = ee; v.exp_ist = ei;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, basic grant path, masking/W1C and register edge cases
    tbl[0]  = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_PENDING, 32'h0,  0, 0);
    tbl[1]  = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_ENABLE,  32'h0,  0, 0);
    tbl[2]  = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_CLAIMED, 32'h0,  0, 0);
    tbl[3]  = mk(1, IRQ_ENABLE, 32'h2,  4'h0, 0, IRQ_ENABLE,  32'h2,  0, 0);
    tbl[4]  = mk(0, 4'h0, 32'h0,        4'h2, 0, IRQ_PENDING, 32'h2,  0, 0);
    tbl[5]  = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_PENDING, 32'h2,  1, 0);
    tbl[6]  = mk(0, 4'h0, 32'h0,        4'h0, 1, IRQ_PENDING, 32'h0,  0, 0);
    tbl[7]  = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_CLAIMED, 32'h11, 0, 0);
    tbl[8]  = mk(1, IRQ_ENABLE, 32'h0,  4'h0, 0, IRQ_ENABLE,  32'h0,  0, 0);
    tbl[9]  = mk(0, 4'h0, 32'h0,        4'h2, 0, IRQ_PENDING, 32'h2,  0, 0);
    tbl[10] = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_PENDING, 32'h2,  0, 0);
    tbl[11] = mk(1, IRQ_PENDING, 32'h2, 4'h0, 0, IRQ_PENDING, 32'h0,  0, 0);
    tbl[12] = mk(1, IRQ_ENABLE, 32'h2,  4'h0, 0, IRQ_ENABLE,  32'h2,  0, 0);
    tbl[13] = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_PENDING, 32'h0,  0, 0);
    tbl[14] = mk(1, 4'hC, 32'hFFFFFFFF, 4'h0, 0, 4'hC,        32'h0,  0, 0);
    tbl[15] = mk(0, 4'h0, 32'h0,        4'h0, 0, IRQ_ENABLE,  32'h2,  0, 0);
    tbl[16] = mk(1, IRQ_ENABLE, 32'hFFFFFFFF, 4'h0, 0, IRQ_ENABLE, 32'hF, 0, 0);
    tbl[17] = mk(1, IRQ_ENABLE, 32'h0,  4'h0, 0, IRQ_ENABLE,  32'h0,  0, 0);
    tbl[18] = mk(0, 4'h0, 32'h0,        4'h0, 1, IRQ_CLAIMED, 32'h11, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].ir, tbl[i].rp, tbl[i].ra);
      chk($sformatf("vec%0d_spo", i), spo, tbl[i].exp_spo);
      chk($sformatf("vec%0d_eip", i), {31'd0, eip}, {31'd0, tbl[i].exp_eip});
      chk($sformatf("vec%0d_ist", i), {31'd0, eip_istimer}, {31'd0, tbl[i].exp_ist});
    end

    // Priority: timer and source 3 together; timer first, then 3 after the holdoff gap
    step(1'b1, IRQ_ENABLE, 32'hF, 4'h0, 1'b0, IRQ_ENABLE);
    chk("prio_enable", spo, 32'hF);
    step(1'b0, 4'h0, 32'd0, 4'h9, 1'b0, IRQ_PENDING);
    chk("prio_pending", spo, 32'h9);
    sb.push_back('{ist: 1'b1, claimed: 32'h10});
    sb.push_back('{ist: 1'b0, claimed: 32'h13});
    service(4'h0, 1);
    idle(IRQ_PENDING);
    chk("holdoff_gap1", {31'd0, eip}, 32'd0);
    chk("prio_pending_after", spo, 32'h8);
    idle(IRQ_CLAIMED);
    chk("holdoff_gap2", {31'd0, eip}, 32'd0);
    idle(IRQ_CLAIMED);
    chk("holdoff_regrant", {31'd0, eip}, 32'd1);
    service(4'h0, 0);
    idle(IRQ_PENDING);
    chk("prio_drained", spo, 32'h0);

    // Set/clear collision: re-pulse of the granted source during reply survives
    step(1'b0, 4'h0, 32'd0, 4'h4, 1'b0, IRQ_PENDING);
    chk("coll_pending", spo, 32'h4);
    sb.push_back('{ist: 1'b0, claimed: 32'h12});
    sb.push_back('{ist: 1'b0, claimed: 32'h12});
    service(4'h4, 0);
    idle(IRQ_PENDING);
    chk("coll_bit_kept", spo, 32'h4);
    service(4'h0, 0);
    idle(IRQ_PENDING);
    chk("coll_drained", spo, 32'h0);

    // Withdrawal during REQ cannot drop eip; reset mid-request clears everything
    repeat (4) idle(IRQ_PENDING);
    step(1'b1, IRQ_ENABLE, 32'h2, 4'h0, 1'b0, IRQ_ENABLE);
    step(1'b0, 4'h0, 32'd0, 4'h2, 1'b0, IRQ_PENDING);
    wait_eip();
    step(1'b1, IRQ_ENABLE, 32'h8, 4'h0, 1'b0, IRQ_ENABLE);
    chk("wd_enable", spo, 32'h8);
    chk("wd_eip_after_en", {31'd0, eip}, 32'd1);
    step(1'b1, IRQ_PENDING, 32'h2, 4'h0, 1'b0, IRQ_PENDING);
    chk("wd_pending_cleared", spo, 32'h0);
    chk("wd_eip_after_w1c", {31'd0, eip}, 32'd1);
    chk("wd_ist", {31'd0, eip_istimer}, 32'd0);
    step(1'b0, 4'h0, 32'd0, 4'h8, 1'b0, IRQ_PENDING);
    chk("wd_pending_other", spo, 32'h8);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a = IRQ_PENDING;
    #1;
    chk("rst_eip", {31'd0, eip}, 32'd0);
    chk("rst_pending", spo, 32'h0);
    a = IRQ_ENABLE;
    #1;
    chk("rst_enable", spo, 32'h0);
    a = IRQ_CLAIMED;
    #1;
    chk("rst_claimed", spo, 32'h0);
    idle(IRQ_PENDING);
    chk("post_rst_eip", {31'd0, eip}, 32'd0);

`ifdef IRQ_AGGREGATOR_ROUNDROBIN_EN
    // Round-robin among 1..3 with re-pulses, timer preempts the rotation
    step(1'b1, IRQ_ENABLE, 32'hE, 4'h0, 1'b0, IRQ_ENABLE);
    step(1'b0, 4'h0, 32'd0, 4'hE, 1'b0, IRQ_PENDING);
    chk("rr_pending", spo, 32'hE);
    sb.push_back('{ist: 1'b0, claimed: 32'h11});
    sb.push_back('{ist: 1'b0, claimed: 32'h12});
    sb.push_back('{ist: 1'b0, claimed: 32'h13});
    sb.push_back('{ist: 1'b0, claimed: 32'h11});
    service(4'h2, 0);
    service(4'h4, 0);
    service(4'h8, 0);
    step(1'b1, IRQ_ENABLE, 32'hF, 4'h0, 1'b0, IRQ_ENABLE);
    sb.push_back('{ist: 1'b1, claimed: 32'h10});
    service(4'h3, 0);
    sb.push_back('{ist: 1'b0, claimed: 32'h11});
    sb.push_back('{ist: 1'b0, claimed: 32'h12});
    sb.push_back('{ist: 1'b0, claimed: 32'h13});
    service(4'h0, 0);
    service(4'h0, 0);
    service(4'h0, 0);
    service(4'h0, 0);
    idle(IRQ_PENDING);
    chk("rr_drained", spo, 32'h0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
